// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-requester AXI write arbiter with W-order FIFO and B routing
// Optional AXI_WR_ARB_FIXED_PRIO_EN: S0 wins every contested AW grant instead of round-robin.
module axi_wr_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ORDER_DEPTH     = 4
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] S0_AXI_AWADDR,
  input  logic [3:0]  S0_AXI_AWID,
  input  logic [7:0]  S0_AXI_AWLEN,
  input  logic        S0_AXI_AWVALID,
  output logic        S0_AXI_AWREADY,
  input  logic [31:0] S0_AXI_WDATA,
  input  logic [3:0]  S0_AXI_WSTRB,
  input  logic        S0_AXI_WLAST,
  input  logic        S0_AXI_WVALID,
  output logic        S0_AXI_WREADY,
  output logic [3:0]  S0_AXI_BID,
  output logic [1:0]  S0_AXI_BRESP,
  output logic        S0_AXI_BVALID,
  input  logic        S0_AXI_BREADY,
  input  logic [31:0] S1_AXI_AWADDR,
  input  logic [3:0]  S1_AXI_AWID,
  input  logic [7:0]  S1_AXI_AWLEN,
  input  logic        S1_AXI_AWVALID,
  output logic        S1_AXI_AWREADY,
  input  logic [31:0] S1_AXI_WDATA,
  input  logic [3:0]  S1_AXI_WSTRB,
  input  logic        S1_AXI_WLAST,
  input  logic        S1_AXI_WVALID,
  output logic        S1_AXI_WREADY,
  output logic [3:0]  S1_AXI_BID,
  output logic [1:0]  S1_AXI_BRESP,
  output logic        S1_AXI_BVALID,
  input  logic        S1_AXI_BREADY,
  output logic [31:0] M_AXI_AWADDR,
  output logic [3:0]  M_AXI_AWID,
  output logic [7:0]  M_AXI_AWLEN,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [3:0]  M_AXI_BID,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);
  localparam int PW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic                   aw_valid_q, aw_valid_d;
  logic [31:0]            aw_addr_q, aw_addr_d;
  logic [3:0]             aw_id_q, aw_id_d;
  logic [7:0]             aw_len_q, aw_len_d;
  logic [ORDER_DEPTH-1:0] ord_q, ord_d;
  logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             out_q, out_d;

  logic fifo_empty, fifo_full, head, w_route, w_pop;
  logic b_sel, b_hs, can_accept, grant, win;
  logic unused_awid;

  assign unused_awid = S0_AXI_AWID[3] ^ S1_AXI_AWID[3];

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(ORDER_DEPTH));
  assign head       = ord_q[rd_q];
  assign w_route    = !fifo_empty && !ARESET;

  // W path follows the FIFO head only; the other requester is held off.
  assign M_AXI_WDATA   = head ? S1_AXI_WDATA : S0_AXI_WDATA;
  assign M_AXI_WSTRB   = head ? S1_AXI_WSTRB : S0_AXI_WSTRB;
  assign M_AXI_WLAST   = head ? S1_AXI_WLAST : S0_AXI_WLAST;
  assign M_AXI_WVALID  = w_route && (head ? S1_AXI_WVALID : S0_AXI_WVALID);
  assign S0_AXI_WREADY = w_route && !head && M_AXI_WREADY;
  assign S1_AXI_WREADY = w_route && head && M_AXI_WREADY;
  assign w_pop         = M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST;

  assign b_sel         = M_AXI_BID[3];
  assign M_AXI_BREADY  = !ARESET && (b_sel ? S1_AXI_BREADY : S0_AXI_BREADY);
  assign S0_AXI_BVALID = !ARESET && M_AXI_BVALID && !b_sel;
  assign S1_AXI_BVALID = !ARESET && M_AXI_BVALID && b_sel;
  assign S0_AXI_BID    = {1'b0, M_AXI_BID[2:0]};
  assign S1_AXI_BID    = {1'b0, M_AXI_BID[2:0]};
  assign S0_AXI_BRESP  = M_AXI_BRESP;
  assign S1_AXI_BRESP  = M_AXI_BRESP;
  assign b_hs          = M_AXI_BVALID && M_AXI_BREADY;

  // A full FIFO still takes a new entry when the head burst retires this cycle.
  assign can_accept = !ARESET && (!aw_valid_q || M_AXI_AWREADY) && (!fifo_full || w_pop)
                      && (out_q < 3'(MAX_OUTSTANDING));
  assign grant      = can_accept && (S0_AXI_AWVALID || S1_AXI_AWVALID);

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
  assign win = !S0_AXI_AWVALID;
`else
  logic prio_q, prio_d;
  assign win    = (S0_AXI_AWVALID && S1_AXI_AWVALID) ? prio_q : S1_AXI_AWVALID;
  assign prio_d = grant ? !win : prio_q;
`endif

  assign S0_AXI_AWREADY = grant && !win;
  assign S1_AXI_AWREADY = grant && win;
  assign M_AXI_AWVALID  = aw_valid_q && !ARESET;
  assign M_AXI_AWADDR   = aw_addr_q;
  assign M_AXI_AWID     = aw_id_q;
  assign M_AXI_AWLEN    = aw_len_q;

  always_comb begin
    aw_valid_d = aw_valid_q;
    aw_addr_d  = aw_addr_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    ord_d      = ord_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q + CW'(grant) - CW'(w_pop);
    out_d      = out_q;
    if (aw_valid_q && M_AXI_AWREADY) aw_valid_d = 1'b0;
    if (grant) begin
      aw_valid_d = 1'b1;
      aw_addr_d  = win ? S1_AXI_AWADDR : S0_AXI_AWADDR;
      aw_id_d    = {win, win ? S1_AXI_AWID[2:0] : S0_AXI_AWID[2:0]};
      aw_len_d   = win ? S1_AXI_AWLEN : S0_AXI_AWLEN;
      ord_d[wr_q] = win;
      wr_d       = wr_q + 1'b1;
    end
    if (w_pop) rd_d = rd_q + 1'b1;
    if (grant && !b_hs) out_d = out_q + 3'd1;
    else if (!grant && b_hs && out_q != 3'd0) out_d = out_q - 3'd1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      ord_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
      prio_q     <= 1'b0;
`endif
    end else begin
      aw_valid_q <= aw_valid_d;
      aw_addr_q  <= aw_addr_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      ord_q      <= ord_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
      prio_q     <= prio_d;
`endif
    end
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - randomized bench for axi_wr_arbiter against a queue-based reference model
module tb_axi_wr_arbiter;
  localparam int MAXO  = 4;
  localparam int DEPTH = 4;
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [1:0][31:0] s_awaddr, s_wdata;
  logic [1:0][3:0]  s_awid, s_wstrb, s_bid;
  logic [1:0][7:0]  s_awlen;
  logic [1:0][1:0]  s_bresp;
  logic [1:0] s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_awid, m_wstrb, m_bid;
  logic [7:0]  m_awlen;
  logic [1:0]  m_bresp;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  axi_wr_arbiter #(.MAX_OUTSTANDING(MAXO), .ORDER_DEPTH(DEPTH)) dut (
    .ACLK(aclk), .ARESET(areset),
    .S0_AXI_AWADDR(s_awaddr[0]), .S0_AXI_AWID(s_awid[0]), .S0_AXI_AWLEN(s_awlen[0]),
    .S0_AXI_AWVALID(s_awvalid[0]), .S0_AXI_AWREADY(s_awready[0]),
    .S0_AXI_WDATA(s_wdata[0]), .S0_AXI_WSTRB(s_wstrb[0]), .S0_AXI_WLAST(s_wlast[0]),
    .S0_AXI_WVALID(s_wvalid[0]), .S0_AXI_WREADY(s_wready[0]),
    .S0_AXI_BID(s_bid[0]), .S0_AXI_BRESP(s_bresp[0]), .S0_AXI_BVALID(s_bvalid[0]),
    .S0_AXI_BREADY(s_bready[0]),
    .S1_AXI_AWADDR(s_awaddr[1]), .S1_AXI_AWID(s_awid[1]), .S1_AXI_AWLEN(s_awlen[1]),
    .S1_AXI_AWVALID(s_awvalid[1]), .S1_AXI_AWREADY(s_awready[1]),
    .S1_AXI_WDATA(s_wdata[1]), .S1_AXI_WSTRB(s_wstrb[1]), .S1_AXI_WLAST(s_wlast[1]),
    .S1_AXI_WVALID(s_wvalid[1]), .S1_AXI_WREADY(s_wready[1]),
    .S1_AXI_BID(s_bid[1]), .S1_AXI_BRESP(s_bresp[1]), .S1_AXI_BVALID(s_bvalid[1]),
    .S1_AXI_BREADY(s_bready[1]),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWID(m_awid), .M_AXI_AWLEN(m_awlen),
    .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WLAST(m_wlast),
    .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
    .M_AXI_BID(m_bid), .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
  } aw_t;

  // Reference model: pending M AW transfer, owner order of accepted bursts, outstanding count.
  aw_t maw[$];
  int  ord[$];
  int  eout, eprio;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int aw_left[2], w_left[2], beat[2], acc_cnt[2];
  logic [1:0][7:0] blen;
  bit [1:0] aw_en, w_en;
  int aw_rate, w_rate, awr_rate, wr_rate, br_rate, b_rate;
  bit b_en, b_auto;
  logic [3:0] bq[$];
  bit [1:0] hs_aw, hs_w, hs_wlast;
  bit hs_maw, hs_b;
  logic [3:0] m_awid_obs;
  logic [1:0] obs_wready;
  int acc_log[$], wl_log[$];
  int first_b_cyc, acc5_cyc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    logic [1:0] e_awr, e_wr, e_bv;
    logic e_mawv, e_mwv, e_mbr, pop, ok, bsel;
    int win, h;
    bit hv;
    aw_t t;
    for (int n = 0; n < 2; n++) begin
      hs_aw[n]    = s_awvalid[n] && s_awready[n];
      hs_w[n]     = s_wvalid[n] && s_wready[n];
      hs_wlast[n] = hs_w[n] && s_wlast[n];
      if (hs_aw[n]) begin
        acc_log.push_back(n);
        acc_cnt[n]++;
        if (n == 0 && acc_cnt[0] == 5) acc5_cyc = cyc;
      end
      if (hs_wlast[n]) wl_log.push_back(n);
    end
    hs_maw     = m_awvalid && m_awready;
    hs_b       = m_bvalid && m_bready;
    m_awid_obs = m_awid;
    obs_wready = s_wready;
    if (hs_b && first_b_cyc < 0) first_b_cyc = cyc;

    if (areset) begin
      check("rst_valid_ready", {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}, 0);
      maw.delete();
      ord.delete();
      eout  = 0;
      eprio = 0;
    end else begin
      hv     = ord.size() > 0;
      h      = hv ? ord[0] : 0;
      e_mawv = maw.size() > 0;
      e_mwv  = hv && s_wvalid[h];
      e_wr   = 2'b00;
      if (hv) e_wr[h] = m_wready;
      pop = e_mwv && m_wready && s_wlast[h];
      ok  = (!e_mawv || m_awready) && (ord.size() < DEPTH || pop) && (eout < MAXO);
      win = -1;
      if (ok) begin
        if (s_awvalid[0] && s_awvalid[1]) win = FIXED_PRIO ? 0 : eprio;
        else if (s_awvalid[0]) win = 0;
        else if (s_awvalid[1]) win = 1;
      end
      e_awr = 2'b00;
      if (win >= 0) e_awr[win] = 1'b1;
      bsel  = m_bid[3];
      e_bv  = 2'b00;
      e_bv[bsel] = m_bvalid;
      e_mbr = s_bready[bsel];

      check("awready", s_awready, e_awr);
      check("m_awvalid", m_awvalid, e_mawv);
      if (e_mawv) check("m_aw_payload", {m_awaddr, m_awid, m_awlen}, {maw[0].addr, maw[0].id, maw[0].len});
      check("wready", s_wready, e_wr);
      check("m_wvalid", m_wvalid, e_mwv);
      if (e_mwv) check("m_wbeat", {m_wdata, m_wstrb, m_wlast}, {s_wdata[h], s_wstrb[h], s_wlast[h]});
      check("bvalid", s_bvalid, e_bv);
      check("m_bready", m_bready, e_mbr);
      check("bid_bresp", {s_bid[1], s_bresp[1], s_bid[0], s_bresp[0]},
            {1'b0, m_bid[2:0], m_bresp, 1'b0, m_bid[2:0], m_bresp});

      if (e_mawv && m_awready) void'(maw.pop_front());
      if (win >= 0) begin
        t.addr = s_awaddr[win];
        t.id   = {win[0], s_awid[win][2:0]};
        t.len  = s_awlen[win];
        maw.push_back(t);
        ord.push_back(win);
        eprio = 1 - win;
        eout++;
      end
      if (pop) void'(ord.pop_front());
      if (m_bvalid && e_mbr) eout--;
    end
  endtask

  task automatic drive();
    for (int n = 0; n < 2; n++) begin
      if (hs_aw[n]) aw_left[n]--;
      if (hs_w[n]) begin
        if (s_wlast[n]) begin
          w_left[n]--;
          beat[n] = 0;
        end else beat[n]++;
      end
      if (!(s_awvalid[n] && !hs_aw[n])) begin
        s_awvalid[n] = aw_en[n] && aw_left[n] > 0 && ($urandom_range(99) < aw_rate);
        s_awaddr[n]  = $urandom;
        s_awid[n]    = 4'($urandom_range(7));
        s_awlen[n]   = blen[n];
      end
      if (!(s_wvalid[n] && !hs_w[n])) begin
        s_wvalid[n] = w_en[n] && w_left[n] > 0 && ($urandom_range(99) < w_rate);
        s_wdata[n]  = $urandom;
        s_wstrb[n]  = 4'($urandom);
        s_wlast[n]  = (beat[n] == int'(blen[n]));
      end
      s_bready[n] = ($urandom_range(99) < br_rate);
    end
    if (hs_maw) bq.push_back(m_awid_obs);
    if (hs_b && bq.size() > 0) void'(bq.pop_front());
    m_awready = ($urandom_range(99) < awr_rate);
    m_wready  = ($urandom_range(99) < wr_rate);
    if (b_auto && !(m_bvalid && !hs_b)) begin
      m_bvalid = b_en && bq.size() > 0 && ($urandom_range(99) < b_rate);
      m_bid    = (bq.size() > 0) ? bq[0] : 4'h0;
      m_bresp  = 2'($urandom);
    end
  endtask

  task automatic step();
    #1;
    check_cycle();
    @(negedge aclk);
    cyc++;
    drive();
  endtask

  task automatic set_rates(input int aw, input int w, input int awr, input int wr, input int br);
    aw_rate = aw; w_rate = w; awr_rate = awr; wr_rate = wr; br_rate = br; b_rate = br;
  endtask

  task automatic setup(input int n, input int bursts, input int len);
    aw_left[n] += bursts;
    w_left[n]  += bursts;
    blen[n]     = 8'(len);
  endtask

  task automatic do_reset(input int ncyc);
    areset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      aw_left[n] = 0; w_left[n] = 0; beat[n] = 0; acc_cnt[n] = 0;
    end
    aw_en = 2'b11; w_en = 2'b11; b_en = 1'b1; b_auto = 1'b1;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; m_bvalid = 1'b0;
    hs_aw = '0; hs_w = '0; hs_maw = 1'b0; hs_b = 1'b0;
    bq.delete(); acc_log.delete(); wl_log.delete();
    first_b_cyc = -1; acc5_cyc = -1;
    repeat (ncyc) step();
    areset = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((aw_left[0] > 0 || aw_left[1] > 0 || w_left[0] > 0 || w_left[1] > 0) && k < budget) begin
      step();
      k++;
    end
    check({tag, "_completed"}, k < budget, 1);
  endtask

  initial begin
    int k;
    bit s0done;
    areset = 1'b1;
    s_awaddr = '0; s_wdata = '0; s_awid = '0; s_wstrb = '0; s_awlen = '0;
    s_awvalid = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0; blen = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    set_rates(100, 100, 100, 100, 100);

    // Reset state: registered AW payload is cleared.
    do_reset(3);
    #1;
    check("rst_aw_payload", {m_awvalid, m_awaddr, m_awid, m_awlen}, 0);

`ifndef AXI_WR_ARB_FIXED_PRIO_EN
    // Both requesters contend for 4 bursts each: grants and W bursts alternate.
    do_reset(2);
    set_rates(100, 100, 100, 100, 100);
    setup(0, 4, 3);
    setup(1, 4, 3);
    run_until_idle("alt", 400);
    check("alt_grant_count", acc_log.size(), 8);
    check("alt_wlast_count", wl_log.size(), 8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++) check("alt_grant_order", acc_log[i], i % 2);
    for (int i = 0; i < 8 && i < wl_log.size(); i++) check("alt_w_order", wl_log[i], i % 2);
`else
    // Fixed priority: S0 takes every grant while both keep requesting.
    do_reset(2);
    set_rates(100, 100, 100, 100, 100);
    setup(0, 4, 0);
    setup(1, 4, 0);
    run_until_idle("fixed", 400);
    check("fixed_grant_count", acc_log.size(), 8);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) check("fixed_s0_first", acc_log[i], 0);
`endif

    // Outstanding limit: B withheld, only 4 of 6 accepted; 5th follows first B by one cycle.
    do_reset(2);
    set_rates(100, 100, 100, 100, 100);
    b_en = 1'b0;
    setup(0, 6, 0);
    repeat (30) step();
    check("os_accepted_before_b", acc_cnt[0], 4);
    b_en = 1'b1;
    run_until_idle("os", 200);
    check("os_fifth_after_first_b", acc5_cyc - first_b_cyc, 1);
    check("os_total_accepted", acc_cnt[0], 6);

    // S1 presents W early, but AW order is S0 then S1.
    do_reset(2);
    set_rates(100, 100, 100, 100, 100);
    setup(0, 1, 1);
    setup(1, 1, 1);
    aw_en[1] = 1'b0;
    w_en[0]  = 1'b0;
    s0done   = 1'b0;
    k = 0;
    while ((aw_left[0] > 0 || aw_left[1] > 0 || w_left[0] > 0 || w_left[1] > 0) && k < 200) begin
      step();
      if (k == 2) aw_en[1] = 1'b1;
      if (k == 8) w_en[0] = 1'b1;
      if (!s0done) begin
        check("s1_wready_held", obs_wready[1], 0);
        if (hs_wlast[0]) s0done = 1'b1;
      end
      k++;
    end
    check("order_completed", k < 200, 1);
    check("order_wlast_count", wl_log.size(), 2);
    if (wl_log.size() == 2) check("order_wlast_seq", {wl_log[0][1:0], wl_log[1][1:0]}, 4'b0001);

    // B routing by BID[3].
    do_reset(2);
    set_rates(0, 0, 0, 0, 0);
    b_auto   = 1'b0;
    m_bvalid = 1'b1;
    m_bid    = 4'h9;
    m_bresp  = 2'b10;
    #1;
    check("b9_s1_bvalid", s_bvalid[1], 1);
    check("b9_s1_bid", s_bid[1], 4'h1);
    check("b9_s0_bvalid", s_bvalid[0], 0);
    check("b9_s1_bresp", s_bresp[1], 2'b10);
    step();
    m_bid = 4'h3;
    #1;
    check("b3_s0_bvalid", {s_bvalid[1], s_bvalid[0]}, 2'b01);
    step();
    m_bvalid = 1'b0;

    // Reset for one cycle in the middle of a W burst.
    do_reset(2);
    set_rates(100, 100, 100, 100, 100);
    setup(0, 1, 7);
    k = 0;
    while (beat[0] < 2 && k < 50) begin
      step();
      k++;
    end
    check("midburst_reached", k < 50, 1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    for (int n = 0; n < 2; n++) begin
      aw_left[n] = 0; w_left[n] = 0; beat[n] = 0;
    end
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; m_bvalid = 1'b0;
    hs_aw = '0; hs_w = '0; hs_maw = 1'b0; hs_b = 1'b0;
    bq.delete();
    #1;
    check("post_rst_idle", {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}, 0);
    step();
    acc_cnt[1] = 0;
    setup(1, 1, 0);
    run_until_idle("post_rst_fresh", 50);
    check("post_rst_accepted", acc_cnt[1], 1);

    // Randomized traffic with random back-pressure on every channel.
    do_reset(2);
    for (int seg = 0; seg < 8; seg++) begin
      set_rates($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100),
                $urandom_range(30, 100), $urandom_range(20, 100));
      for (int n = 0; n < 2; n++) if (beat[n] == 0) blen[n] = 8'($urandom_range(3));
      for (int i = 0; i < 200; i++) begin
        for (int n = 0; n < 2; n++)
          if (aw_left[n] == 0 && $urandom_range(9) == 0) setup(n, $urandom_range(1, 3), int'(blen[n]));
        step();
      end
    end
    check("rand_activity", acc_cnt[0] > 0 && acc_cnt[1] > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of accepted AW bursts awaiting a B response (range 1-7).
REQ-002 SHALL have parameter ORDER_DEPTH, default 4, meaning the W-order FIFO entries (power of 2, at least 2).
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have, for each requester n in {0,1}, ports Sn_AXI_AWADDR in 32, Sn_AXI_AWID in 4, Sn_AXI_AWLEN in 8, Sn_AXI_AWVALID in 1, Sn_AXI_AWREADY out 1: the requester's write-address channel.
REQ-006 SHALL have, per requester, ports Sn_AXI_WDATA in 32, Sn_AXI_WSTRB in 4, Sn_AXI_WLAST in 1, Sn_AXI_WVALID in 1, Sn_AXI_WREADY out 1: the requester's write-data channel.
REQ-007 SHALL have, per requester, ports Sn_AXI_BID out 4, Sn_AXI_BRESP out 2, Sn_AXI_BVALID out 1, Sn_AXI_BREADY in 1: the requester's write-response channel.
REQ-008 SHALL have downstream ports M_AXI_AWADDR out 32, M_AXI_AWID out 4, M_AXI_AWLEN out 8, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1: the shared slave's write-address channel.
REQ-009 SHALL have downstream ports M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WLAST out 1, M_AXI_WVALID out 1, M_AXI_WREADY in 1, M_AXI_BID in 4, M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1: the shared slave's write-data and write-response channels.

Function
REQ-010 SHALL accept an AW from a requester only when all of these hold: the M AW register is empty or handshaking this cycle, the order FIFO is not full, and outstanding < MAX_OUTSTANDING.
REQ-011 SHALL, on acceptance, pulse the winner's Sn_AXI_AWREADY for exactly one cycle, hold the loser's AWREADY at 0, and register the AW onto M_AXI_AW* with 1-cycle latency.
REQ-012 SHALL drive M_AXI_AWID = {n, Sn_AXI_AWID[2:0]}; requesters SHALL use IDs 0-7 only.
REQ-013 SHALL arbitrate round-robin: after a grant to n, requester 1-n has priority next; after reset, S0 has priority; a lone request is granted regardless of priority.
REQ-014 SHALL hold M_AXI_AWVALID and its payload stable until M_AXI_AWREADY is sampled high.
REQ-015 SHALL push the winner index into the order FIFO on each AW acceptance.
REQ-016 SHALL connect the W channel of the FIFO-head requester combinationally to M_AXI_W*, with M_AXI_WREADY returned only to that requester; the other requester's WREADY SHALL be 0.
REQ-017 SHALL pop the FIFO on an M W handshake with WLAST=1; when the FIFO is empty, M_AXI_WVALID=0 and both WREADY=0.
REQ-018 SHALL allow W beats of a burst to pass before its AW handshakes on M, but never before that AW is accepted from the requester.
REQ-019 SHALL route B by M_AXI_BID[3]: Sn_AXI_BVALID = M_AXI_BVALID when n matches, Sn_AXI_BID = {0, M_AXI_BID[2:0]}, M_AXI_BREADY = the selected Sn_AXI_BREADY.
REQ-020 SHALL keep the outstanding counter as: +1 on AW acceptance, -1 on M B handshake, unchanged when both occur in the same cycle.
REQ-021 SHALL accept an AW and pop the FIFO in the same cycle when the FIFO is full.

Reset
REQ-022 SHALL, while ARESET=1, drive all VALID/READY outputs to 0, clear the FIFO, clear the outstanding counter and set priority to S0; registered payload outputs SHALL reset to 0.
REQ-023 SHALL, on ARESET mid-burst, abandon in-flight bursts; on the cycle after release, no grant or W routing SHALL be pending.

Configuration
REQ-024 SHALL use macro AXI_WR_ARB_FIXED_PRIO_EN: when defined, S0 wins every contested grant; when undefined, arbitration is round-robin per REQ-013.

Verification
REQ-025 SHALL cover the case where both requesters assert AWVALID simultaneously for 4 bursts each, with AWLEN=3: M grants SHALL alternate S0,S1,S0,... and W beats SHALL follow the same order.
REQ-026 SHALL cover the case where M_AXI_BVALID is held at 0 and S0 issues 6 bursts: exactly 4 are accepted, and the 5th is accepted 1 cycle after the first B handshake.
REQ-027 SHALL cover the case where S1 presents all W beats before S0, while AW order is S0 then S1: S1_AXI_WREADY SHALL stay 0 until the S0 WLAST handshake.
REQ-028 SHALL cover M_AXI_BID=4'h9 with BVALID=1: S1_AXI_BVALID=1, S1_AXI_BID=4'h1, S0_AXI_BVALID=0.
REQ-029 SHALL cover the case with AXI_WR_ARB_FIXED_PRIO_EN defined and both requesters continuously requesting: S0 wins every grant.
REQ-030 SHALL cover ARESET asserted for 1 cycle mid W burst: all VALID/READY outputs are 0 the next cycle, the counter is 0, and a fresh AW is accepted afterward.
